raystore_nport: RTL and testbench

- Parametrised successor to the ray store front end.
- N requester channels share a dual-port block RAM holding ray vectors. Each cycle a round-robin arbiter grants up to two reads, one per RAM port.
- Each channel's returned data travels with its sideband tag through a per-channel response FIFO to its own downstream consumer.
- Improvements: rotating-priority pointer, credit-based acceptance (no pipe/FIFO overflow), and a host write that steals only port A, so one read still proceeds during loads.

---
 rtl/raystore_pkg.sv | 6 +
 rtl/fifo.sv | 47 ++++
 rtl/raystore_bram.sv | 34 +++
 rtl/raystore_rr_arb.sv | 57 +++++
 rtl/raystore_nport.sv | 113 +++++++++++
 tb/tb_raystore_nport.sv | 220 ++++++++++++++++++++++
 6 files changed

// File: rtl/raystore_pkg.sv
// Shared types for the multi-port ray store: ray vector type and RAM port identifiers.
package raystore_pkg;
    localparam int RS_DATA_W = 192;
    typedef logic [RS_DATA_W-1:0] ray_vec_t;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} rs_port_e;
endpackage

// File: rtl/fifo.sv
// Generic circular FIFO with registered storage and occupancy count; no fall-through.
// Push is visible on pop_dat_o the cycle after; the caller must never push when full or pop when empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_rdy_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_vld_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_rdy_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_vld_i, pop_rdy_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = cnt_q;
endmodule

// File: rtl/raystore_bram.sv
// Simple dual-port RAM: port A read/write, port B read-only, RD_LAT-cycle registered reads.
// A port-B read of the address port A is writing returns the old contents.
module raystore_bram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 192,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdat_i,
    output logic [DATA_W-1:0] a_q_o,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic [DATA_W-1:0] b_q_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q    [DEPTH];
    logic [DATA_W-1:0] a_pipe_q [RD_LAT];
    logic [DATA_W-1:0] b_pipe_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (a_we_i) mem_q[a_addr_i] <= a_wdat_i;
        a_pipe_q[0] <= mem_q[a_addr_i];
        b_pipe_q[0] <= mem_q[b_addr_i];
        for (int s = 1; s < RD_LAT; s++) begin
            a_pipe_q[s] <= a_pipe_q[s-1];
            b_pipe_q[s] <= b_pipe_q[s-1];
        end
    end

    assign a_q_o = a_pipe_q[RD_LAT-1];
    assign b_q_o = b_pipe_q[RD_LAT-1];
endmodule

// File: rtl/raystore_rr_arb.sv
// Rotating-priority arbiter granting up to two channels per cycle (one when the host write owns port A).
// Combinational grant; the priority pointer moves just past the last granted channel.
module raystore_rr_arb
    import raystore_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  elig_i,
    input  logic             we_i,
    output logic [N_CH-1:0]  grant_o,
    output logic [N_CH-1:0]  port_sel_o,
    output logic [IDX_W-1:0] mux_sel_a_o,
    output logic [IDX_W-1:0] mux_sel_b_o
);
    logic [IDX_W-1:0] rrp_q, rrp_d;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic [1:0]       n_gnt, budget;

    always_comb begin
        grant_o     = '0;
        port_sel_o  = '0;
        mux_sel_a_o = '0;
        mux_sel_b_o = '0;
        rrp_d       = rrp_q;
        sum         = '0;
        idx         = '0;
        n_gnt       = 2'd0;
        budget      = we_i ? 2'd1 : 2'd2;
        for (int k = 0; k < N_CH; k++) begin
            sum = {1'b0, rrp_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_CH)) sum = sum - (IDX_W+1)'(N_CH);
            idx = sum[IDX_W-1:0];
            if (elig_i[idx] && (n_gnt < budget)) begin
                grant_o[idx] = 1'b1;
                // While the host writes, port A is busy, so the lone grant goes to port B.
                if ((n_gnt == 2'd0) && !we_i) begin
                    port_sel_o[idx] = PORT_A;
                    mux_sel_a_o     = idx;
                end else begin
                    port_sel_o[idx] = PORT_B;
                    mux_sel_b_o     = idx;
                end
                rrp_d = (idx == IDX_W'(N_CH - 1)) ? '0 : idx + 1'b1;
                n_gnt = n_gnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rrp_q <= '0;
        else     rrp_q <= rrp_d;
    end
endmodule

// File: rtl/raystore_nport.sv
// N-channel ray store: arbitrated dual-port RAM reads returned through per-channel response FIFOs.
// Request-to-response latency RD_LAT+1; credit-based acceptance stalls a channel whose FIFO could overflow.
module raystore_nport
    import raystore_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = RS_DATA_W,
    parameter int TAG_W      = 64,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          us_valid,
    output logic [N_CH-1:0]          us_stall,
    input  logic [N_CH*ADDR_W-1:0]   us_addr,
    input  logic [N_CH*TAG_W-1:0]    us_tag,
    output logic [N_CH-1:0]          ds_valid,
    input  logic [N_CH-1:0]          ds_stall,
    output logic [N_CH*DATA_W-1:0]   ds_data,
    output logic [N_CH*TAG_W-1:0]    ds_tag,
    input  logic                     raystore_we,
    input  logic [ADDR_W-1:0]        raystore_write_addr,
    input  logic [DATA_W-1:0]        raystore_write_data
);
    localparam int IDX_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W  = $clog2(RD_LAT + 1);
    localparam int FW    = DATA_W + TAG_W;

    logic [N_CH-1:0]   elig, grant, port_sel;
    logic [IDX_W-1:0]  mux_sel_a, mux_sel_b;
    logic [ADDR_W-1:0] addr_ch [N_CH];
    logic [DATA_W-1:0] q_a, q_b;

    assign us_stall = us_valid & ~grant;

    raystore_rr_arb #(.N_CH(N_CH)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .elig_i      (elig),
        .we_i        (raystore_we),
        .grant_o     (grant),
        .port_sel_o  (port_sel),
        .mux_sel_a_o (mux_sel_a),
        .mux_sel_b_o (mux_sel_b)
    );

    raystore_bram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_bram (
        .clk      (clk),
        .a_we_i   (raystore_we),
        .a_addr_i (raystore_we ? raystore_write_addr : addr_ch[mux_sel_a]),
        .a_wdat_i (raystore_write_data),
        .a_q_o    (q_a),
        .b_addr_i (addr_ch[mux_sel_b]),
        .b_q_o    (q_b)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [RD_LAT-1:0] pipe_vld_q, pipe_sel_q;
        logic [TAG_W-1:0]  pipe_tag_q [RD_LAT];
        logic [IF_W-1:0]   inflight_q;
        logic [CNT_W-1:0]  fifo_cnt;
        logic [FW-1:0]     pop_dat;
        logic              push;

        assign addr_ch[i] = us_addr[i*ADDR_W +: ADDR_W];
        // FIFO entries plus reads still in the pipe can never exceed the FIFO depth.
        assign elig[i] = us_valid[i] & ~rst &
                         (({1'b0, fifo_cnt} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FIFO_DEPTH));
        assign push = pipe_vld_q[RD_LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_vld_q <= '0;
                inflight_q <= '0;
            end else begin
                pipe_vld_q[0] <= grant[i];
                for (int s = 1; s < RD_LAT; s++) pipe_vld_q[s] <= pipe_vld_q[s-1];
                case ({grant[i], push})
                    2'b10:   inflight_q <= inflight_q + 1'b1;
                    2'b01:   inflight_q <= inflight_q - 1'b1;
                    default: inflight_q <= inflight_q;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            pipe_sel_q[0] <= port_sel[i];
            pipe_tag_q[0] <= us_tag[i*TAG_W +: TAG_W];
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_sel_q[s] <= pipe_sel_q[s-1];
                pipe_tag_q[s] <= pipe_tag_q[s-1];
            end
        end

        fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_vld_i (push),
            .push_dat_i ({(rs_port_e'(pipe_sel_q[RD_LAT-1]) == PORT_B) ? q_b : q_a,
                          pipe_tag_q[RD_LAT-1]}),
            .pop_rdy_i  (ds_valid[i] & ~ds_stall[i]),
            .pop_dat_o  (pop_dat),
            .count_o    (fifo_cnt)
        );

        assign ds_valid[i]                 = ~rst & (fifo_cnt != '0);
        assign ds_data[i*DATA_W +: DATA_W] = pop_dat[FW-1:TAG_W];
        assign ds_tag[i*TAG_W +: TAG_W]    = pop_dat[TAG_W-1:0];
    end
endmodule

// File: tb/tb_raystore_nport.sv
// Scoreboard bench for raystore_nport: memory model predicts every response, arbitration checked per cycle.
module tb_raystore_nport;
    localparam int N_CH = 4, ADDR_W = 9, DATA_W = 192, TAG_W = 64, RD_LAT = 2, FIFO_DEPTH = 4;
    localparam int RW = DATA_W + TAG_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        us_valid, us_stall, ds_valid, ds_stall;
    logic [N_CH*ADDR_W-1:0] us_addr;
    logic [N_CH*TAG_W-1:0]  us_tag;
    logic [N_CH*DATA_W-1:0] ds_data;
    logic [N_CH*TAG_W-1:0]  ds_tag;
    logic                   raystore_we;
    logic [ADDR_W-1:0]      raystore_write_addr;
    logic [DATA_W-1:0]      raystore_write_data;

    raystore_nport #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
                     .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .us_valid(us_valid), .us_stall(us_stall), .us_addr(us_addr),
        .us_tag(us_tag), .ds_valid(ds_valid), .ds_stall(ds_stall), .ds_data(ds_data),
        .ds_tag(ds_tag), .raystore_we(raystore_we), .raystore_write_addr(raystore_write_addr),
        .raystore_write_data(raystore_write_data)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem_m [1 << ADDR_W];
    logic [RW-1:0]     exp_q [N_CH][$];
    int n_tests = 0, n_fail = 0, tagc = 0;

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int a);
        if (a == 5) return {24{8'hA5}};
        return {6{32'h5A00_0000 | 32'(a)}};
    endfunction

    task automatic set_req(input int ch, input int a);
        tagc++;
        us_addr[ch*ADDR_W +: ADDR_W] = ADDR_W'(a);
        us_tag[ch*TAG_W +: TAG_W]    = {32'hC0C0_0000 | 32'(ch), 32'(tagc)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int left;
        left = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            left = 0;
            for (int i = 0; i < N_CH; i++) left += exp_q[i].size();
            if (left == 0) break;
        end
        chk("drain", left, 0);
        step();
    endtask

    // Scoreboard: compare outputs, then record accepted requests, then apply host writes (old-data reads).
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) exp_q[i].delete();
        end else begin
            chk("stall_without_valid", us_stall & ~us_valid, 0);
            for (int i = 0; i < N_CH; i++) begin
                if (ds_valid[i] && exp_q[i].size() == 0)
                    chk($sformatf("ds%0d_unexpected", i), ds_valid[i], 0);
                else if (ds_valid[i] && !ds_stall[i])
                    chk($sformatf("ds%0d_resp", i),
                        {ds_data[i*DATA_W +: DATA_W], ds_tag[i*TAG_W +: TAG_W]},
                        exp_q[i].pop_front());
                if (us_valid[i] && !us_stall[i])
                    exp_q[i].push_back({mem_m[us_addr[i*ADDR_W +: ADDR_W]], us_tag[i*TAG_W +: TAG_W]});
            end
        end
        if (raystore_we) mem_m[raystore_write_addr] = raystore_write_data;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000ns");
        $fatal(1);
    end

    initial begin
        logic [N_CH-1:0] g;
        int n, nxt [N_CH];
        rst = 1'b1; us_valid = '1; ds_stall = '0; us_addr = '0; us_tag = '0;
        raystore_we = 1'b0; raystore_write_addr = '0; raystore_write_data = '0;
        step();
        @(negedge clk);
        chk("rst_ds_valid", ds_valid, 0);
        chk("rst_us_stall", us_stall, us_valid);
        step();
        rst = 1'b0; us_valid = '0;

        for (int a = 0; a < 16; a++) begin
            raystore_we = 1'b1; raystore_write_addr = ADDR_W'(a); raystore_write_data = pat(a);
            step();
        end
        raystore_we = 1'b0;

        // Single request latency.
        set_req(0, 5); us_valid = 4'b0001;
        @(negedge clk);
        chk("lat_accept", us_stall[0], 0);
        step();
        us_valid = '0;
        for (int c = 1; c <= RD_LAT + 1; c++) begin
            @(negedge clk);
            chk($sformatf("lat_c%0d", c), ds_valid[0], (c == RD_LAT + 1));
        end
        drain();

        // All channels busy after reset: pairs {0,1},{2,3} alternate.
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < N_CH; i++) begin nxt[i] = i * 3; set_req(i, nxt[i]); end
        us_valid = '1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            g = us_valid & ~us_stall;
            chk($sformatf("rr_all_c%0d", c), g, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            step();
            for (int i = 0; i < N_CH; i++)
                if (g[i]) begin nxt[i] = (nxt[i] + 1) % 16; set_req(i, nxt[i]); end
        end
        us_valid = '0;
        drain();

        // Host write holding port A: one grant per cycle, alternating 0 and 2, served by port B.
        raystore_we = 1'b1;
        nxt[0] = 1; nxt[2] = 10; set_req(0, nxt[0]); set_req(2, nxt[2]);
        us_valid = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            raystore_write_addr = ADDR_W'(32 + c); raystore_write_data = pat(32 + c);
            @(negedge clk);
            g = us_valid & ~us_stall;
            chk($sformatf("we_grant_c%0d", c), g, (c % 2 == 0) ? 4'b0001 : 4'b0100);
            step();
            for (int i = 0; i < N_CH; i++)
                if (g[i]) begin nxt[i] = (nxt[i] + 1) % 16; set_req(i, nxt[i]); end
        end
        raystore_we = 1'b0; us_valid = '0;
        drain();

        // Credit limit with a stalled consumer.
        ds_stall = 4'b0010; nxt[1] = 2; set_req(1, nxt[1]); us_valid = 4'b0010;
        n = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            g = us_valid & ~us_stall;
            if (c == 15) chk("credit_stall", us_stall[1], 1);
            step();
            if (g[1]) begin n++; nxt[1] = (nxt[1] + 1) % 16; set_req(1, nxt[1]); end
        end
        chk("credit_xfers", n, FIFO_DEPTH);
        ds_stall = '0; n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            g = us_valid & ~us_stall;
            step();
            if (g[1]) begin n++; nxt[1] = (nxt[1] + 1) % 16; set_req(1, nxt[1]); end
        end
        chk("credit_resume", (n >= 5), 1);
        us_valid = '0;
        drain();

        // Read-during-write on port B returns old data; next cycle sees the new value.
        raystore_we = 1'b1; raystore_write_addr = 7; raystore_write_data = {6{32'hDEAD_BEEF}};
        set_req(0, 7); us_valid = 4'b0001;
        @(negedge clk);
        chk("rdw_accept", us_stall[0], 0);
        step();
        raystore_we = 1'b0; set_req(0, 7);
        @(negedge clk);
        chk("rdw_next_accept", us_stall[0], 0);
        step();
        us_valid = '0;
        drain();

        // Reset with two responses queued and three reads in flight.
        ds_stall = '1; set_req(0, 1); us_valid = 4'b0001;
        step(); set_req(0, 2);
        step(); us_valid = '0;
        repeat (3) step();
        set_req(1, 3); set_req(2, 4); us_valid = 4'b0110;
        @(negedge clk);
        chk("mid_grant_12", us_valid & ~us_stall, 4'b0110);
        step(); set_req(3, 6); us_valid = 4'b1000;
        @(negedge clk);
        chk("mid_grant_3", us_valid & ~us_stall, 4'b1000);
        step();
        rst = 1'b1; us_valid = '1;
        @(negedge clk);
        chk("mid_rst_ds_valid", ds_valid, 0);
        chk("mid_rst_us_stall", us_stall, 4'b1111);
        step();
        rst = 1'b0;
        for (int i = 0; i < N_CH; i++) set_req(i, 8 + i);
        @(negedge clk);
        chk("mid_rrp_restart", us_valid & ~us_stall, 4'b0011);
        step();
        us_valid = '0; ds_stall = '0;
        drain();
        repeat (10) @(negedge clk);
        chk("post_rst_idle", ds_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
